// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: default memory
// geometry, starvation default and the access-state encoding.
package imem_pkg;

    localparam int IM_AW          = 11;
    localparam int IM_DEPTH       = 1 << IM_AW;
    localparam int IM_DW          = 16;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LD_RD = 2'd2,
        LD_WR = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_arb.sv
// Single-port instruction-memory arbiter between CPU fetch and program loader.
// Grants are combinational; read data returns one cycle after the grant.
//
// state | meaning
// IDLE  | no memory access this cycle
// FETCH | CPU read issued this cycle
// LD_RD | loader readback issued this cycle
// LD_WR | loader write issued this cycle
module imem_arb
    import imem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int AW         = IM_AW
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              fetch_req,
    input  logic [AW-1:0]     fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_vld,
    output logic [IM_DW-1:0]  fetch_instr,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [IM_DW-1:0]  ld_wdata,
    output logic              ld_gnt,
    output logic              ld_vld,
    output logic [IM_DW-1:0]  ld_rdata,

    input  logic              ld_lock,
    output logic              cpu_stall,

    output logic [AW-1:0]     mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [IM_DW-1:0]  mem_wdata,
    input  logic [IM_DW-1:0]  mem_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    imem_state_e       state_q, state_d;
    logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [IM_DW-1:0]  fetch_instr_q, fetch_instr_d;
    logic [IM_DW-1:0]  ld_rdata_q, ld_rdata_d;
    logic              ld_wins;

    always_comb begin
        state_d      = IDLE;
        ld_wins      = 1'b0;
        cpu_stall    = 1'b0;
        fetch_gnt    = 1'b0;
        ld_gnt       = 1'b0;
        mem_addr     = '0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wdata    = '0;
        starve_cnt_d = starve_cnt_q;

        // Nothing is granted while reset is held, so no access can be in flight.
        if (!rst) begin
            ld_wins = ld_req && (ld_lock || (starve_cnt_q == STARVE_LIM));
            if (fetch_req && !ld_lock && !ld_wins) begin
                state_d = FETCH;
            end else if (ld_req) begin
                state_d = ld_we ? LD_WR : LD_RD;
            end
            cpu_stall = ld_lock || (fetch_req && (state_d != FETCH));
        end

        case (state_d)
            FETCH: begin
                fetch_gnt = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = fetch_addr;
            end
            LD_RD: begin
                ld_gnt    = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = ld_addr;
            end
            LD_WR: begin
                ld_gnt    = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
            end
            default: ;
        endcase

        // Counts fetch wins while the loader is waiting; saturates at the limit.
        if (!ld_req || ld_gnt) begin
            starve_cnt_d = '0;
        end else if (fetch_gnt && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // The memory samples on the falling edge, so mem_rdata is settled by the
    // rising edge that closes the grant cycle.
    always_comb begin
        fetch_instr_d = fetch_instr_q;
        ld_rdata_d    = ld_rdata_q;
        if (state_d == FETCH) begin
            fetch_instr_d = mem_rdata;
        end
        if (state_d == LD_RD) begin
            ld_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            fetch_instr_q <= '0;
            ld_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            fetch_instr_q <= fetch_instr_d;
            ld_rdata_q    <= ld_rdata_d;
        end
    end

    assign fetch_vld   = (state_q == FETCH);
    assign ld_vld      = (state_q == LD_RD);
    assign fetch_instr = fetch_instr_q;
    assign ld_rdata    = ld_rdata_q;

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb: arbitration table plus multi-cycle sequences,
// with a falling-edge memory model behind the arbiter.
module tb_imem_arb;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic        fetch_gnt, fetch_vld;
    logic [15:0] fetch_instr;
    logic        ld_req, ld_we, ld_lock;
    logic [10:0] ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_gnt, ld_vld;
    logic [15:0] ld_rdata;
    logic        cpu_stall;
    logic [10:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic [15:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_arb #(.STARVE_MAX(4), .AW(11)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_vld(fetch_vld), .fetch_instr(fetch_instr),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_vld(ld_vld), .ld_rdata(ld_rdata),
        .ld_lock(ld_lock), .cpu_stall(cpu_stall),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        freq;
        logic [10:0] faddr;
        logic        lreq, lwe, lock;
        logic [10:0] laddr;
        logic [15:0] lwd;
        logic        efg, elg, erd, ewr, estall;
        logic [10:0] eaddr;
        logic        efv, elv;
    } vec_t;

    vec_t vt [11];

    initial begin
        int nf;
        bit saw_ld;

        for (int i = 0; i < 2048; i++) mem[i] = 16'hA000 + 16'(i);

        //           freq faddr  lreq lwe lock laddr   lwd      fg lg rd wr st eaddr   fv lv
        vt[0]  = '{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 11'h003, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h100, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'h100, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 11'h003, 1'b1, 1'b1, 1'b0, 11'h200, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h003, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 11'h003, 1'b1, 1'b1, 1'b0, 11'h200, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h003, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 11'h003, 1'b1, 1'b1, 1'b0, 11'h200, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h003, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 11'h003, 1'b1, 1'b1, 1'b0, 11'h200, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'h003, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 11'h003, 1'b1, 1'b1, 1'b0, 11'h200, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 11'h003, 1'b0, 1'b0, 1'b1, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h200, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h200, 1'b0, 1'b0};
        vt[10] = '{1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1};

        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;

        // Requests during reset must not be granted.
        #3;
        fetch_req = 1'b1; ld_req = 1'b1;
        tick; tick;
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_fetch_vld", 32'(fetch_vld), 32'd0);
        chk("rst_ld_vld", 32'(ld_vld), 32'd0);
        chk("rst_fetch_instr", 32'(fetch_instr), 32'h0);
        chk("rst_ld_rdata", 32'(ld_rdata), 32'h0);
        fetch_req = 1'b0; ld_req = 1'b0;
        tick;
        rst = 1'b0;

        // Arbitration table, one row per cycle.
        for (int k = 0; k < 11; k++) begin
            tick;
            fetch_req = vt[k].freq; fetch_addr = vt[k].faddr;
            ld_req = vt[k].lreq; ld_we = vt[k].lwe; ld_lock = vt[k].lock;
            ld_addr = vt[k].laddr; ld_wdata = vt[k].lwd;
            #1;
            chk($sformatf("row%0d_fetch_gnt", k), 32'(fetch_gnt), 32'(vt[k].efg));
            chk($sformatf("row%0d_ld_gnt", k), 32'(ld_gnt), 32'(vt[k].elg));
            chk($sformatf("row%0d_rd_en", k), 32'(mem_rd_en), 32'(vt[k].erd));
            chk($sformatf("row%0d_wr_en", k), 32'(mem_wr_en), 32'(vt[k].ewr));
            chk($sformatf("row%0d_stall", k), 32'(cpu_stall), 32'(vt[k].estall));
            chk($sformatf("row%0d_mem_addr", k), 32'(mem_addr), 32'(vt[k].eaddr));
            chk($sformatf("row%0d_fetch_vld", k), 32'(fetch_vld), 32'(vt[k].efv));
            chk($sformatf("row%0d_ld_vld", k), 32'(ld_vld), 32'(vt[k].elv));
            if (vt[k].ewr) chk($sformatf("row%0d_wdata", k), 32'(mem_wdata), 32'(vt[k].lwd));
        end

        // Fetch-only stream at 0..3.
        for (int i = 0; i < 4; i++) begin
            tick;
            fetch_req = 1'b1; fetch_addr = 11'(i);
            #1;
            chk($sformatf("stream_gnt%0d", i), 32'(fetch_gnt), 32'd1);
            if (i > 0) begin
                chk($sformatf("stream_vld%0d", i), 32'(fetch_vld), 32'd1);
                chk($sformatf("stream_instr%0d", i), 32'(fetch_instr), 32'hA000 + 32'(i - 1));
            end
        end
        tick;
        fetch_req = 1'b0;
        #1;
        chk("stream_vld_last", 32'(fetch_vld), 32'd1);
        chk("stream_instr_last", 32'(fetch_instr), 32'hA003);
        tick; #1;
        chk("stream_vld_drop", 32'(fetch_vld), 32'd0);
        chk("stream_instr_hold", 32'(fetch_instr), 32'hA003);

        // Read issued just before lock rises still completes.
        tick;
        fetch_req = 1'b1; fetch_addr = 11'h006;
        #1;
        chk("prelock_gnt", 32'(fetch_gnt), 32'd1);
        tick;
        ld_lock = 1'b1;
        #1;
        chk("lock_no_gnt", 32'(fetch_gnt), 32'd0);
        chk("lock_stall", 32'(cpu_stall), 32'd1);
        chk("prelock_vld", 32'(fetch_vld), 32'd1);
        chk("prelock_instr", 32'(fetch_instr), 32'hA006);
        tick;
        ld_lock = 1'b0; fetch_req = 1'b0;

        // Starvation: both requesters held constant.
        tick;
        fetch_req = 1'b1; fetch_addr = 11'h020;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'h7FF;
        nf = 0; saw_ld = 1'b0;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (ld_gnt) begin
                saw_ld = 1'b1;
                break;
            end
            if (fetch_gnt) nf++;
            tick;
        end
        chk("starve_ld_gnt_seen", 32'(saw_ld), 32'd1);
        chk("starve_fetch_wins", 32'(nf), 32'd4);
        chk("starve_ld_addr", 32'(mem_addr), 32'h7FF);
        tick;
        chk("starve_ld_vld", 32'(ld_vld), 32'd1);
        chk("starve_ld_rdata", 32'(ld_rdata), 32'hA7FF);
        chk("starve_fetch_resume", 32'(fetch_gnt), 32'd1);
        tick;
        fetch_req = 1'b0; ld_req = 1'b0;

        // Locked loader write then readback.
        tick;
        ld_lock = 1'b1; fetch_req = 1'b1; fetch_addr = 11'h020;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'h010; ld_wdata = 16'h1234;
        #1;
        chk("lockwr_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("lockwr_ld_gnt", 32'(ld_gnt), 32'd1);
        chk("lockwr_wr_en", 32'(mem_wr_en), 32'd1);
        chk("lockwr_stall", 32'(cpu_stall), 32'd1);
        tick;
        ld_we = 1'b0;
        #1;
        chk("lockrd_fetch_gnt", 32'(fetch_gnt), 32'd0);
        chk("lockrd_rd_en", 32'(mem_rd_en), 32'd1);
        tick;
        ld_req = 1'b0;
        #1;
        chk("lockrd_vld", 32'(ld_vld), 32'd1);
        chk("lockrd_data", 32'(ld_rdata), 32'h1234);
        chk("lockrd_stall", 32'(cpu_stall), 32'd1);
        tick;
        ld_lock = 1'b0; fetch_req = 1'b0;

        // Write followed by fetch of the same word.
        tick;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'h005; ld_wdata = 16'hBEEF;
        #1;
        chk("coll_wr_gnt", 32'(ld_gnt), 32'd1);
        tick;
        ld_req = 1'b0; fetch_req = 1'b1; fetch_addr = 11'h005;
        #1;
        chk("coll_fetch_gnt", 32'(fetch_gnt), 32'd1);
        tick;
        fetch_req = 1'b0;
        #1;
        chk("coll_vld", 32'(fetch_vld), 32'd1);
        chk("coll_instr", 32'(fetch_instr), 32'hBEEF);

        // Reset landing right after a fetch grant.
        tick;
        fetch_req = 1'b1; fetch_addr = 11'h001;
        #1;
        chk("rstmid_gnt", 32'(fetch_gnt), 32'd1);
        tick;
        rst = 1'b1;
        #1;
        chk("rstmid_vld", 32'(fetch_vld), 32'd0);
        chk("rstmid_instr", 32'(fetch_instr), 32'h0);
        chk("rstmid_state", 32'(dut.state_q), 32'(IDLE));
        chk("rstmid_no_gnt", 32'(fetch_gnt), 32'd0);
        chk("rstmid_stall", 32'(cpu_stall), 32'd0);
        tick; #1;
        chk("rstmid_vld_hold", 32'(fetch_vld), 32'd0);
        tick;
        rst = 1'b0; fetch_addr = 11'h002;
        #1;
        chk("postrst_gnt", 32'(fetch_gnt), 32'd1);
        tick;
        fetch_req = 1'b0;
        #1;
        chk("postrst_vld", 32'(fetch_vld), 32'd1);
        chk("postrst_instr", 32'(fetch_instr), 32'hA002);

        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
